// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues one word request per cycle at pc, presents fetched words on code
// with a one-cycle code_valid strobe, parks one word in a skid register
// when downstream stalls, and redirects on branch_taken.
// Optional feature: define FETCH_TIMEOUT_EN to enable the request timeout
// (sticky fetch_err plus HALT after 16 unacknowledged REQ cycles).
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [23:0] imem_data,
  output logic [23:0] code,
  output logic        code_valid,
  output logic [15:0] pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [15:0] pc_d;
  logic [23:0] code_d;
  logic        code_valid_d;
  logic [23:0] skid, skid_d;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0]  to_cnt, to_cnt_d;
  logic        err_q, err_d;
  logic        timeout_hit;

  // A request expires on its 16th consecutive unacknowledged REQ cycle.
  always_comb begin
    timeout_hit = (state == REQ) && !imem_ack && (to_cnt == 4'hF);
  end

  // Timeout counter runs only while waiting in REQ; any ack, branch or exit clears it.
  always_comb begin
    to_cnt_d = '0;
    err_d    = err_q;
    if ((state == REQ) && !imem_ack && !branch_taken) begin
      if (to_cnt == 4'hF) begin
        err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt + 4'd1;
      end
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= to_cnt_d;
      err_q  <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Request outputs follow the state register; the address is always pc.
  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = pc;
  end

  // Next-state and datapath updates; a branch overrides everything except HALT.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    code_d       = code;
    code_valid_d = 1'b0;
    skid_d       = skid;

    case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          pc_d = pc + 16'd1;
          if (stall) begin
            skid_d  = imem_data;
            state_d = HOLD;
          end else begin
            code_d       = imem_data;
            code_valid_d = 1'b1;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = HALT;
        end
`endif
      end
      HOLD: begin
        if (!stall) begin
          code_d       = skid;
          code_valid_d = 1'b1;
          state_d      = REQ;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Branch redirect: drops any coincident ack data and the skid word,
    // and spends one IDLE cycle so the outstanding request is aborted.
    if (branch_taken && (state != HALT)) begin
      pc_d         = branch_target;
      code_d       = code;
      code_valid_d = 1'b0;
      skid_d       = '0;
      state_d      = IDLE;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      skid       <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      code       <= code_d;
      code_valid <= code_valid_d;
      skid       <= skid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven bench for fetch_unit, plus a
// hand-written timeout sequence (behaviour depends on FETCH_TIMEOUT_EN).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [23:0] imem_data;
  logic [23:0] code;
  logic        code_valid;
  logic [15:0] pc;
  logic        fetch_err;

  int unsigned n_vec;
  int unsigned n_err;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .code          (code),
    .code_valid    (code_valid),
    .pc            (pc),
    .fetch_err     (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic        ack;
    logic [15:0] tgt;
    logic [23:0] data;
    logic        e_req;
    logic [15:0] e_pc;
    logic [23:0] e_code;
    logic        e_cv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic b, input logic a,
                     input logic [15:0] t, input logic [23:0] d,
                     input logic eq, input logic [15:0] ep,
                     input logic [23:0] ec, input logic ev);
    vec_t v;
    v.rst_n = r; v.stall = s; v.br = b; v.ack = a; v.tgt = t; v.data = d;
    v.e_req = eq; v.e_pc = ep; v.e_code = ec; v.e_cv = ev;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int unsigned idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic a,
                       input logic [15:0] t, input logic [23:0] d);
    rst_n = r; stall = s; branch_taken = b; imem_ack = a;
    branch_target = t; imem_data = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 24'h000000);

    //   rst stl br ack target    data          req  pc        code          cv
    add(0, 0, 0, 0, 16'h0000, 24'h000000,   0, 16'h0000, 24'h000000, 0); // reset
    add(1, 0, 0, 0, 16'h0000, 24'h000000,   1, 16'h0000, 24'h000000, 0); // IDLE->REQ
    add(1, 0, 0, 1, 16'h0000, 24'h100000,   1, 16'h0001, 24'h100000, 1);
    add(1, 0, 0, 1, 16'h0000, 24'h100001,   1, 16'h0002, 24'h100001, 1);
    add(1, 0, 0, 1, 16'h0000, 24'h100002,   1, 16'h0003, 24'h100002, 1);
    add(1, 1, 0, 1, 16'h0000, 24'h100003,   0, 16'h0004, 24'h100002, 0); // into HOLD
    add(1, 1, 0, 0, 16'h0000, 24'h000000,   0, 16'h0004, 24'h100002, 0); // hold
    add(1, 0, 0, 0, 16'h0000, 24'h000000,   1, 16'h0004, 24'h100003, 1); // skid out
    add(1, 0, 0, 1, 16'h0000, 24'h100004,   1, 16'h0005, 24'h100004, 1);
    add(1, 0, 0, 0, 16'h0000, 24'h000000,   1, 16'h0005, 24'h100004, 0); // wait
    add(1, 0, 1, 1, 16'h0040, 24'h100005,   0, 16'h0040, 24'h100004, 0); // branch+ack
    add(1, 0, 0, 0, 16'h0000, 24'h000000,   1, 16'h0040, 24'h100004, 0);
    add(1, 0, 0, 1, 16'h0000, 24'hABCDEF,   1, 16'h0041, 24'hABCDEF, 1);
    add(1, 0, 1, 0, 16'hFFFF, 24'h000000,   0, 16'hFFFF, 24'hABCDEF, 0); // preset FFFF
    add(1, 0, 0, 0, 16'h0000, 24'h000000,   1, 16'hFFFF, 24'hABCDEF, 0);
    add(1, 0, 0, 1, 16'h0000, 24'h123456,   1, 16'h0000, 24'h123456, 1); // wrap
    add(1, 1, 0, 1, 16'h0000, 24'h654321,   0, 16'h0001, 24'h123456, 0); // HOLD
    add(1, 1, 1, 0, 16'h0100, 24'h000000,   0, 16'h0100, 24'h123456, 0); // branch in HOLD
    add(1, 0, 0, 0, 16'h0000, 24'h000000,   1, 16'h0100, 24'h123456, 0);
    add(1, 0, 0, 1, 16'h0000, 24'h111111,   1, 16'h0101, 24'h111111, 1);
    add(0, 0, 1, 1, 16'h5555, 24'h222222,   0, 16'h0000, 24'h000000, 0); // reset wins
    add(1, 0, 0, 0, 16'h0000, 24'h000000,   1, 16'h0000, 24'h000000, 0);
    add(1, 1, 0, 0, 16'h0000, 24'h000000,   1, 16'h0000, 24'h000000, 0); // stall, no ack
    add(1, 0, 0, 1, 16'h0000, 24'h0F0F0F,   1, 16'h0001, 24'h0F0F0F, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].br, tbl[i].ack, tbl[i].tgt, tbl[i].data);
      step();
      chk("imem_req",   i, {31'd0, imem_req},   {31'd0, tbl[i].e_req});
      chk("pc",         i, {16'd0, pc},         {16'd0, tbl[i].e_pc});
      chk("code",       i, {8'd0, code},        {8'd0, tbl[i].e_code});
      chk("code_valid", i, {31'd0, code_valid}, {31'd0, tbl[i].e_cv});
      chk("fetch_err",  i, {31'd0, fetch_err},  32'd0);
      if (tbl[i].e_req)
        chk("imem_addr", i, {16'd0, imem_addr}, {16'd0, tbl[i].e_pc});
    end

    // Timeout sequence: reset, enter REQ, then never acknowledge.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 24'h000000);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 24'h000000);
    step();
    chk("to_enter_req", 0, {31'd0, imem_req}, 32'd1);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("to_wait_req", i, {31'd0, imem_req},  32'd1);
      chk("to_wait_err", i, {31'd0, fetch_err}, 32'd0);
    end
    step();
`ifdef FETCH_TIMEOUT_EN
    chk("to_err_set",  16, {31'd0, fetch_err}, 32'd1);
    chk("to_halt_req", 16, {31'd0, imem_req},  32'd0);
    // HALT ignores branch and stall.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 24'h777777);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 24'h000000);
    step();
    chk("halt_pc",     17, {16'd0, pc},         32'd0);
    chk("halt_req",    17, {31'd0, imem_req},   32'd0);
    chk("halt_cv",     17, {31'd0, code_valid}, 32'd0);
    chk("halt_err",    17, {31'd0, fetch_err},  32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 24'h000000);
    step();
    chk("rst_clr_err", 18, {31'd0, fetch_err},  32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 24'h000000);
    step();
    chk("rst_resume",  19, {31'd0, imem_req},   32'd1);
`else
    chk("no_to_err16", 16, {31'd0, fetch_err}, 32'd0);
    chk("no_to_req16", 16, {31'd0, imem_req},  32'd1);
    for (int i = 17; i <= 100; i++) step();
    chk("no_to_err100", 100, {31'd0, fetch_err}, 32'd0);
    chk("no_to_req100", 100, {31'd0, imem_req},  32'd1);
    chk("no_to_pc100",  100, {16'd0, pc},        32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
